scan_sched: RTL and testbench



---
 rtl/scan_pkg.sv | 7 +
 rtl/step_timer.sv | 21 ++
 rtl/scan_sched.sv | 74 +++++++
 tb/tb_scan_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM states, speed limits and address split for the memory viewer scheduler.
package scan_pkg;
   typedef enum logic [1:0] {READ, LAT, WAIT, PAUSED} state_t;
   localparam logic [1:0] SPD_MIN = 2'd0;
   localparam logic [1:0] SPD_MAX = 2'd3;
   localparam int INSTR_BIT = 7;
endpackage

// File: rtl/step_timer.sv
// step_timer: down-counter timing the idle gap between reads; reload leaves P-1-RD_LAT cycles of WAIT.
module step_timer #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int RD_LAT = 1,
   localparam int W = $clog2(CLK_FREQ)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       clear,
   input  logic [1:0] lvl,
   output logic       done
);
   logic [W-1:0] cnt;
   logic [W-1:0] reload;
   assign reload = W'((CLK_FREQ >> lvl) - RD_LAT - 2);
   assign done = cnt == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (load || clear) ? reload : done ? cnt : cnt - W'(1);
endmodule

// File: rtl/scan_sched.sv
// scan_sched: steps an 8-bit view address over data/instruction memory, one read per step,
// and publishes each captured word with its address to the display path.
module scan_sched
   import scan_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pause,
   input  logic        speedup,
   input  logic        speeddown,
   input  logic [31:0] instr_rdata,
   input  logic [31:0] data_rdata,
   output logic [6:0]  mem_addr,
   output logic        instr_rd_en,
   output logic        data_rd_en,
   output logic [7:0]  disp_addr,
   output logic [31:0] disp_data,
   output logic        disp_vld,
   output logic [1:0]  status
);
   state_t state, state_nx;
   logic [7:0] rd_ptr;
   logic [1:0] lvl, lvl_nx, lat_cnt;
   logic pause_q, lat_done, spd_chg, t_done;
   assign lat_done = state == LAT && lat_cnt == 2'(RD_LAT - 1);
   assign spd_chg = (speedup ^ speeddown) && (speedup ? lvl != SPD_MAX : lvl != SPD_MIN);
   assign lvl_nx = !spd_chg ? lvl : speedup ? lvl + 2'd1 : lvl - 2'd1;
   assign status = lvl;
   assign mem_addr = rd_ptr[INSTR_BIT-1:0];
   // gated by rst_n so no strobe leaks out while reset holds the FSM in READ
   assign instr_rd_en = rst_n && state == READ && rd_ptr[INSTR_BIT];
   assign data_rd_en = rst_n && state == READ && !rd_ptr[INSTR_BIT];
   step_timer #(.CLK_FREQ(CLK_FREQ), .RD_LAT(RD_LAT)) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (lat_done),
      .clear((state == PAUSED && pause) || (state == WAIT && spd_chg)),
      .lvl  (lvl_nx),
      .done (t_done)
   );
   always_comb begin
      state_nx = state;
      case (state)
         READ:    state_nx = LAT;
         LAT:     state_nx = !lat_done ? LAT : (pause || pause_q) ? PAUSED : WAIT;
         WAIT:    state_nx = pause ? PAUSED : (t_done && !spd_chg) ? READ : WAIT;
         PAUSED:  state_nx = pause ? WAIT : PAUSED;
         default: state_nx = READ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= READ;
         rd_ptr <= '0;
         lvl <= SPD_MIN;
         lat_cnt <= '0;
         pause_q <= 1'b0;
         disp_addr <= '0;
         disp_data <= '0;
         disp_vld <= 1'b0;
      end else begin
         state <= state_nx;
         lvl <= lvl_nx;
         lat_cnt <= state == LAT ? lat_cnt + 2'd1 : 2'd0;
         pause_q <= !lat_done && (pause_q || (pause && (state == READ || state == LAT)));
         disp_vld <= lat_done;
         disp_addr <= lat_done ? rd_ptr : disp_addr;
         disp_data <= !lat_done ? disp_data : rd_ptr[INSTR_BIT] ? instr_rdata : data_rdata;
         rd_ptr <= lat_done ? rd_ptr + 8'd1 : rd_ptr;
      end
endmodule

// File: tb/tb_scan_sched.sv
// tb_scan_sched: directed checks of step timing, address walk, speed, pause and reset behaviour.
module tb_scan_sched;
   localparam int CLK_FREQ = 64;
   localparam int RD_LAT = 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pause = 1'b0, speedup = 1'b0, speeddown = 1'b0;
   logic [31:0] instr_rdata = '0, data_rdata = '0;
   logic [6:0] mem_addr;
   logic instr_rd_en, data_rd_en, disp_vld;
   logic [7:0] disp_addr;
   logic [31:0] disp_data;
   logic [1:0] status;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   scan_sched #(.CLK_FREQ(CLK_FREQ), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pause      (pause),
      .speedup    (speedup),
      .speeddown  (speeddown),
      .instr_rdata(instr_rdata),
      .data_rdata (data_rdata),
      .mem_addr   (mem_addr),
      .instr_rd_en(instr_rd_en),
      .data_rd_en (data_rd_en),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_vld   (disp_vld),
      .status     (status)
   );
   function automatic logic [31:0] dmem(input logic [6:0] a);
      return a == 7'd0 ? 32'h1234_5678 : {25'd0, a};
   endfunction
   function automatic logic [31:0] imem(input logic [6:0] a);
      return a == 7'd0 ? 32'hDEAD_BEEF : {25'd0, a} | 32'hC000_0000;
   endfunction
   // one-cycle-latency memories
   always @(posedge clk) begin
      if (data_rd_en) data_rdata <= dmem(mem_addr);
      if (instr_rd_en) instr_rdata <= imem(mem_addr);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_vld(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!disp_vld && n < 300);
      if (!disp_vld) check("vld_timeout", disp_vld, 1);
   endtask
   task automatic wait_rd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(instr_rd_en || data_rd_en) && n < 300);
      if (!(instr_rd_en || data_rd_en)) check("rd_timeout", instr_rd_en || data_rd_en, 1);
   endtask
   task automatic pulse(input logic u, input logic d, input logic p);
      speedup = u;
      speeddown = d;
      pause = p;
      @(negedge clk);
      speedup = 1'b0;
      speeddown = 1'b0;
      pause = 1'b0;
   endtask
   initial begin
      int n, cnt, cv;
      repeat (3) @(negedge clk);
      check("rst_vld", disp_vld, 0);
      check("rst_addr", disp_addr, 0);
      check("rst_data", disp_data, 0);
      check("rst_status", status, 0);
      check("rst_rd_en", instr_rd_en | data_rd_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst_n = 1'b1;
      #1;
      check("first_data_rd_en", data_rd_en, 1);
      check("first_instr_rd_en", instr_rd_en, 0);
      check("first_mem_addr", mem_addr, 0);
      wait_vld(n);
      check("first_vld_lat", n, 2);
      check("first_addr", disp_addr, 8'h00);
      check("first_data", disp_data, 32'h1234_5678);
      wait_vld(n);
      check("spacing_l0", n, 64);
      check("second_addr", disp_addr, 8'h01);
      check("second_data", disp_data, 32'h1);
      repeat (5) @(negedge clk);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check("status_up3", status, 3);
      wait_vld(n);
      wait_vld(n);
      check("spacing_l3", n, 8);
      pulse(1, 0, 0);
      check("status_up_sat", status, 3);
      wait_vld(n);
      wait_vld(n);
      check("spacing_l3_sat", n, 8);
      cnt = 0;
      while (disp_addr != 8'h7F && cnt < 200) begin
         wait_vld(n);
         cnt++;
      end
      check("addr_7f", disp_addr, 8'h7F);
      check("data_7f", disp_data, 32'h7F);
      wait_rd(n);
      check("rd80_instr_en", instr_rd_en, 1);
      check("rd80_data_en", data_rd_en, 0);
      check("rd80_mem_addr", mem_addr, 0);
      wait_vld(n);
      check("addr_80", disp_addr, 8'h80);
      check("data_80", disp_data, 32'hDEAD_BEEF);
      cnt = 0;
      while (disp_addr != 8'hFF && cnt < 200) begin
         wait_vld(n);
         cnt++;
      end
      check("addr_ff", disp_addr, 8'hFF);
      check("data_ff", disp_data, 32'hC000_007F);
      wait_rd(n);
      check("wrap_data_en", data_rd_en, 1);
      check("wrap_instr_en", instr_rd_en, 0);
      check("wrap_mem_addr", mem_addr, 0);
      wait_vld(n);
      check("wrap_addr", disp_addr, 8'h00);
      check("wrap_data", disp_data, 32'h1234_5678);
      pulse(0, 1, 0);
      check("status_down1", status, 2);
      pulse(1, 1, 0);
      check("status_both", status, 2);
      pulse(0, 1, 0);
      pulse(0, 1, 0);
      pulse(0, 1, 0);
      check("status_down_sat", status, 0);
      wait_vld(n);
      wait_vld(n);
      check("spacing_back_l0", n, 64);
      check("addr_02", disp_addr, 8'h02);
      wait_rd(n);
      pulse(0, 0, 1);
      wait_vld(n);
      check("pause_read_done", n, 1);
      check("pause_read_addr", disp_addr, 8'h03);
      check("pause_read_data", disp_data, 32'h3);
      cnt = 0;
      cv = 0;
      repeat (200) begin
         @(negedge clk);
         cnt += int'(instr_rd_en | data_rd_en);
         cv += int'(disp_vld);
      end
      check("paused_rd", cnt, 0);
      check("paused_vld", cv, 0);
      pulse(0, 0, 1);
      wait_vld(n);
      check("resume_gap", n, 64);
      check("resume_addr", disp_addr, 8'h04);
      repeat (10) @(negedge clk);
      pulse(1, 0, 0);
      wait_vld(n);
      check("midwait_gap", n, 32);
      check("midwait_status", status, 1);
      check("midwait_addr", disp_addr, 8'h05);
      wait_rd(n);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("lat_rst_vld", disp_vld, 0);
      check("lat_rst_addr", disp_addr, 0);
      check("lat_rst_status", status, 0);
      check("lat_rst_rd_en", instr_rd_en | data_rd_en, 0);
      cv = 0;
      repeat (5) begin
         @(negedge clk);
         cv += int'(disp_vld);
      end
      check("lat_rst_no_vld", cv, 0);
      rst_n = 1'b1;
      #1;
      check("restart_data_en", data_rd_en, 1);
      check("restart_mem_addr", mem_addr, 0);
      wait_vld(n);
      check("restart_lat", n, 2);
      check("restart_addr", disp_addr, 8'h00);
      check("restart_data", disp_data, 32'h1234_5678);
      check("restart_status", status, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
